// File: rtl/bp_be_ctxt_switch_ctrl.sv
// Hardware thread switch sequencer driven by CTXT CSR writes: stall FE, drain the BE,
// save the outgoing context, restore the incoming one, flush and resume.
module bp_be_ctxt_switch_ctrl #(
    parameter int unsigned num_threads_p     = 4,
    parameter int unsigned thread_id_width_p = 2,
    parameter int unsigned drain_timeout_p   = 255
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         csr_ctxt_write_v_i,
    input  logic [thread_id_width_p-1:0] csr_ctxt_write_data_i,
    input  logic [num_threads_p-1:0]     thread_en_i,
    input  logic                         pipe_idle_i,
    output logic                         ctx_save_v_o,
    input  logic                         ctx_save_ready_i,
    output logic                         ctx_restore_v_o,
    input  logic                         ctx_restore_ready_i,
    output logic [thread_id_width_p-1:0] ctx_id_o,
    output logic [thread_id_width_p-1:0] current_thread_id_o,
    output logic                         fe_stall_o,
    output logic                         flush_o,
    output logic                         busy_o,
    output logic                         switch_done_o,
    output logic                         illegal_o,
    output logic                         timeout_o
);

    localparam int unsigned cnt_width_lp = $clog2(drain_timeout_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_limit_lp = cnt_width_lp'(drain_timeout_p);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDrain   = 3'd1;
    localparam logic [2:0] StSave    = 3'd2;
    localparam logic [2:0] StRestore = 3'd3;
    localparam logic [2:0] StResume  = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [thread_id_width_p-1:0] cur_id_q, cur_id_d;
    logic [thread_id_width_p-1:0] pending_id_q, pending_id_d;
    logic [cnt_width_lp-1:0]      drain_cnt_q, drain_cnt_d;
    logic                         illegal_q, illegal_d;
    logic                         timeout_q, timeout_d;

    logic [31:0]             target_ext;
    logic                    target_legal;
    logic [cnt_width_lp-1:0] drain_cnt_inc;

    assign target_ext    = 32'(csr_ctxt_write_data_i);
    assign target_legal  = (target_ext < num_threads_p) && thread_en_i[csr_ctxt_write_data_i];
    assign drain_cnt_inc = drain_cnt_q + cnt_width_lp'(1);

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        pending_id_d = pending_id_q;
        drain_cnt_d  = drain_cnt_q;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (csr_ctxt_write_v_i) begin
                    if (!target_legal) begin
                        illegal_d = 1'b1;
                    end else if (csr_ctxt_write_data_i != cur_id_q) begin
                        pending_id_d = csr_ctxt_write_data_i;
                        drain_cnt_d  = '0;
                        state_d      = StDrain;
                    end
                end
            end
            StDrain: begin
                // Idle pipe wins over a timeout landing in the same cycle.
                if (pipe_idle_i) begin
                    state_d = StSave;
                end else if (drain_cnt_inc == cnt_limit_lp) begin
                    timeout_d    = 1'b1;
                    pending_id_d = '0;
                    drain_cnt_d  = '0;
                    state_d      = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_inc;
                end
            end
            StSave: begin
                if (ctx_save_ready_i) state_d = StRestore;
            end
            StRestore: begin
                if (ctx_restore_ready_i) begin
                    cur_id_d = pending_id_q;
                    state_d  = StResume;
                end
            end
            StResume: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            cur_id_q     <= '0;
            pending_id_q <= '0;
            drain_cnt_q  <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_id_q     <= cur_id_d;
            pending_id_q <= pending_id_d;
            drain_cnt_q  <= drain_cnt_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        ctx_save_v_o    = (state_q == StSave);
        ctx_restore_v_o = (state_q == StRestore);
        ctx_id_o        = '0;
        if (ctx_save_v_o)    ctx_id_o = cur_id_q;
        if (ctx_restore_v_o) ctx_id_o = pending_id_q;
    end

    assign current_thread_id_o = cur_id_q;
    assign busy_o              = (state_q != StIdle);
    assign fe_stall_o          = busy_o;
    assign flush_o             = (state_q == StResume);
    assign switch_done_o       = (state_q == StResume);
    assign illegal_o           = illegal_q;
    assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_bp_be_ctxt_switch_ctrl.sv
// Directed bench for bp_be_ctxt_switch_ctrl; a second instance with a short drain limit
// shares the stimulus and is only checked during the timeout steps.
module tb_bp_be_ctxt_switch_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_v;
  logic [1:0] wr_data;
  logic [3:0] thread_en;
  logic       pipe_idle;
  logic       save_rdy;
  logic       rest_rdy;

  logic       a_save_v, a_rest_v, a_stall, a_flush, a_busy, a_done, a_illegal, a_timeout;
  logic [1:0] a_ctx_id, a_cur;
  logic       b_save_v, b_rest_v, b_stall, b_flush, b_busy, b_done, b_illegal, b_timeout;
  logic [1:0] b_ctx_id, b_cur;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bp_be_ctxt_switch_ctrl u_dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .csr_ctxt_write_v_i    (wr_v),
    .csr_ctxt_write_data_i (wr_data),
    .thread_en_i           (thread_en),
    .pipe_idle_i           (pipe_idle),
    .ctx_save_v_o          (a_save_v),
    .ctx_save_ready_i      (save_rdy),
    .ctx_restore_v_o       (a_rest_v),
    .ctx_restore_ready_i   (rest_rdy),
    .ctx_id_o              (a_ctx_id),
    .current_thread_id_o   (a_cur),
    .fe_stall_o            (a_stall),
    .flush_o               (a_flush),
    .busy_o                (a_busy),
    .switch_done_o         (a_done),
    .illegal_o             (a_illegal),
    .timeout_o             (a_timeout)
  );

  bp_be_ctxt_switch_ctrl #(.drain_timeout_p(4)) u_dut_to (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .csr_ctxt_write_v_i    (wr_v),
    .csr_ctxt_write_data_i (wr_data),
    .thread_en_i           (thread_en),
    .pipe_idle_i           (pipe_idle),
    .ctx_save_v_o          (b_save_v),
    .ctx_save_ready_i      (save_rdy),
    .ctx_restore_v_o       (b_rest_v),
    .ctx_restore_ready_i   (rest_rdy),
    .ctx_id_o              (b_ctx_id),
    .current_thread_id_o   (b_cur),
    .fe_stall_o            (b_stall),
    .flush_o               (b_flush),
    .busy_o                (b_busy),
    .switch_done_o         (b_done),
    .illegal_o             (b_illegal),
    .timeout_o             (b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_v      = 1'b0;
    wr_data   = 2'd0;
    thread_en = 4'b1111;
    pipe_idle = 1'b0;
    save_rdy  = 1'b0;
    rest_rdy  = 1'b0;
    #2;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_cur", a_cur, 2'd0);
    chk("rst_stall", a_stall, 1'b0);
    chk("rst_save_v", a_save_v, 1'b0);
    chk("rst_ctx_id", a_ctx_id, 2'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Minimum-latency switch 0 -> 2
    pipe_idle = 1'b1; save_rdy = 1'b1; rest_rdy = 1'b1;
    wr_v = 1'b1; wr_data = 2'd2;
    tick();
    wr_v = 1'b0;
    chk("fast_c1_stall", a_stall, 1'b1);
    chk("fast_c1_done", a_done, 1'b0);
    tick();
    chk("fast_c2_save_v", a_save_v, 1'b1);
    chk("fast_c2_ctx_id", a_ctx_id, 2'd0);
    tick();
    chk("fast_c3_rest_v", a_rest_v, 1'b1);
    chk("fast_c3_ctx_id", a_ctx_id, 2'd2);
    chk("fast_c3_cur", a_cur, 2'd0);
    tick();
    chk("fast_c4_done", a_done, 1'b1);
    chk("fast_c4_flush", a_flush, 1'b1);
    chk("fast_c4_stall", a_stall, 1'b1);
    chk("fast_c4_cur", a_cur, 2'd2);
    tick();
    chk("fast_c5_stall", a_stall, 1'b0);
    chk("fast_c5_done", a_done, 1'b0);
    chk("fast_c5_busy", a_busy, 1'b0);

    // 10-cycle drain, save ready delayed 3 cycles
    pulse_reset();
    pipe_idle = 1'b0; save_rdy = 1'b0; rest_rdy = 1'b0;
    wr_v = 1'b1; wr_data = 2'd2;
    tick();
    wr_v = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("drain_busy", a_busy, 1'b1);
      chk("drain_no_save", a_save_v, 1'b0);
      if (i == 10) pipe_idle = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("save_hold_v", a_save_v, 1'b1);
      chk("save_hold_id", a_ctx_id, 2'd0);
      tick();
    end
    save_rdy = 1'b1;
    chk("save_hs_v", a_save_v, 1'b1);
    tick();
    save_rdy = 1'b0;
    chk("rest_v", a_rest_v, 1'b1);
    chk("rest_no_save", a_save_v, 1'b0);
    chk("rest_id", a_ctx_id, 2'd2);
    tick();
    chk("rest_wait_cur", a_cur, 2'd0);
    chk("rest_wait_v", a_rest_v, 1'b1);
    rest_rdy = 1'b1;
    tick();
    rest_rdy = 1'b0;
    chk("slow_done", a_done, 1'b1);
    chk("slow_cur", a_cur, 2'd2);
    tick();
    chk("slow_idle", a_busy, 1'b0);

    // Illegal target, then write to current thread
    thread_en = 4'b0111;
    wr_v = 1'b1; wr_data = 2'd3;
    tick();
    wr_v = 1'b0;
    chk("illegal_pulse", a_illegal, 1'b1);
    chk("illegal_busy", a_busy, 1'b0);
    tick();
    chk("illegal_clear", a_illegal, 1'b0);
    chk("illegal_cur", a_cur, 2'd2);
    thread_en = 4'b1111;
    wr_v = 1'b1; wr_data = 2'd2;
    tick();
    wr_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("noop_busy", a_busy, 1'b0);
      chk("noop_stall", a_stall, 1'b0);
      chk("noop_flush", a_flush, 1'b0);
      chk("noop_illegal", a_illegal, 1'b0);
      chk("noop_done", a_done, 1'b0);
      tick();
    end

    // Drain timeout on the short-limit instance
    pulse_reset();
    pipe_idle = 1'b0; save_rdy = 1'b1; rest_rdy = 1'b1;
    wr_v = 1'b1; wr_data = 2'd1;
    tick();
    wr_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_drain_busy", b_busy, 1'b1);
      chk("to_drain_timeout", b_timeout, 1'b0);
      chk("to_drain_no_save", b_save_v, 1'b0);
      tick();
    end
    chk("to_pulse", b_timeout, 1'b1);
    chk("to_idle", b_busy, 1'b0);
    chk("to_no_save", b_save_v, 1'b0);
    chk("to_cur", b_cur, 2'd0);
    tick();
    chk("to_clear", b_timeout, 1'b0);

    // Pipe goes idle on the limit cycle: save wins
    pulse_reset();
    wr_v = 1'b1; wr_data = 2'd1;
    tick();
    wr_v = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("lim_drain_busy", b_busy, 1'b1);
      if (i == 4) pipe_idle = 1'b1;
      tick();
    end
    chk("lim_save_v", b_save_v, 1'b1);
    chk("lim_no_timeout", b_timeout, 1'b0);
    tick();
    tick();
    chk("lim_done", b_done, 1'b1);
    chk("lim_cur", b_cur, 2'd1);
    tick();

    // Second write during RESTORE is ignored
    pulse_reset();
    pipe_idle = 1'b1; save_rdy = 1'b1; rest_rdy = 1'b0;
    done_base = done_cnt;
    wr_v = 1'b1; wr_data = 2'd2;
    tick();
    wr_v = 1'b0;
    tick();
    tick();
    chk("ign_in_restore", a_rest_v, 1'b1);
    wr_v = 1'b1; wr_data = 2'd1;
    tick();
    wr_v = 1'b0;
    chk("ign_still_restore", a_rest_v, 1'b1);
    chk("ign_id", a_ctx_id, 2'd2);
    chk("ign_no_illegal", a_illegal, 1'b0);
    rest_rdy = 1'b1;
    tick();
    chk("ign_done", a_done, 1'b1);
    tick();
    tick();
    tick();
    chk("ign_busy", a_busy, 1'b0);
    chk("ign_cur", a_cur, 2'd2);
    chk("ign_one_done", done_cnt - done_base, 1);

    // Asynchronous reset in the middle of SAVE
    save_rdy = 1'b0;
    wr_v = 1'b1; wr_data = 2'd0;
    tick();
    wr_v = 1'b0;
    tick();
    chk("mid_save_v", a_save_v, 1'b1);
    chk("mid_save_id", a_ctx_id, 2'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_save_v", a_save_v, 1'b0);
    chk("arst_stall", a_stall, 1'b0);
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_cur", a_cur, 2'd0);
    chk("arst_ctx_id", a_ctx_id, 2'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", a_busy, 1'b0);
    chk("post_rst_cur", a_cur, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_ctxt_switch_ctrl.md
Name: bp_be_ctxt_switch_ctrl

Overview:
- Consumes the CTXT CSR (0x081) write request produced by the BE system pipe and executes the hardware thread switch.
- Sequence: stall FE, drain the pipeline, save the outgoing thread's context, restore the incoming thread's context, flush, resume.
- Owns and drives the architectural current thread ID that the CSR unit reads back.
- Sits in the BE beside the calculator, between the system pipe and the per-thread context store.

Parameters:
- num_threads_p, 4, number of hardware threads; must be >= 2.
- thread_id_width_p, 2, width of a thread ID; equals $clog2(num_threads_p).
- drain_timeout_p, 255, maximum DRAIN cycles before the switch is aborted; must be >= 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- csr_ctxt_write_v_i  in  1  CTXT CSR write committed this cycle.
- csr_ctxt_write_data_i  in  thread_id_width_p  target thread ID.
- thread_en_i  in  num_threads_p  per-thread enable mask.
- pipe_idle_i  in  1  BE pipeline empty, no in-flight instructions.
- ctx_save_v_o  out  1  save request (valid).
- ctx_save_ready_i  in  1  context store accepts the save.
- ctx_restore_v_o  out  1  restore request (valid).
- ctx_restore_ready_i  in  1  context store completes the restore.
- ctx_id_o  out  thread_id_width_p  thread ID for the active save/restore.
- current_thread_id_o  out  thread_id_width_p  architectural current thread.
- fe_stall_o  out  1  holds FE fetch.
- flush_o  out  1  one-cycle pipeline flush pulse.
- busy_o  out  1  switch in progress (state != IDLE).
- switch_done_o  out  1  one-cycle pulse, switch completed.
- illegal_o  out  1  one-cycle pulse, target rejected.
- timeout_o  out  1  one-cycle pulse, drain aborted.

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=IDLE; current_thread_id_o=0; pending_id=0; drain counter=0; all outputs 0.
- Reset asserted mid-switch aborts immediately; no save or restore is completed; current_thread_id_o returns to 0.
- States: IDLE, DRAIN, SAVE, RESTORE, RESUME.
- IDLE, csr_ctxt_write_v_i=1, target data d:
  - d >= num_threads_p or thread_en_i[d]=0: illegal_o=1 next cycle; stay IDLE.
  - d == current_thread_id_o: no-op; no stall, no flush, no pulses.
  - Otherwise: latch pending_id=d; go DRAIN; clear drain counter.
- fe_stall_o=1 in DRAIN, SAVE, RESTORE and RESUME. busy_o = (state != IDLE).
- DRAIN:
  - pipe_idle_i=1: go SAVE.
  - Else increment the counter. When the counter reaches drain_timeout_p with pipe_idle_i still 0: timeout_o pulse, go IDLE, pending discarded, current ID unchanged.
  - pipe_idle_i=1 in the same cycle the counter reaches the limit: go SAVE; no timeout.
  - Counter width $clog2(drain_timeout_p+1); the counter never wraps.
- SAVE:
  - ctx_save_v_o=1, ctx_id_o=current_thread_id_o.
  - Valid holds until ctx_save_ready_i; the handshake occurs on the cycle both are high. Then go RESTORE.
- RESTORE:
  - ctx_restore_v_o=1, ctx_id_o=pending_id; held until ctx_restore_ready_i.
  - On the handshake: current_thread_id_o<=pending_id; go RESUME.
- RESUME (exactly 1 cycle): flush_o=1, switch_done_o=1; go IDLE. fe_stall_o drops the following cycle.
- Minimum latency, from write_v accepted to switch_done_o: 4 cycles when pipe_idle_i=1 and both readies are already high.
- csr_ctxt_write_v_i while busy_o=1 is ignored; no state change, no illegal pulse. The CSR side must not issue while busy.
- thread_en_i is sampled only at acceptance in IDLE. Later deassertion of the target's enable does not abort the switch.
- ctx_id_o=0 whenever neither save nor restore valid is asserted.
- The save and restore valids are never both high. Neither valid drops before its handshake.

Test Plan:
- Reset then write d=2 with pipe_idle_i=1 and both readies=1 -> current_thread_id_o 0->2; switch_done_o and flush_o high for 1 cycle at cycle 4; fe_stall_o high for cycles 1-4.
- Write d=2 with pipe_idle_i=0 for 10 cycles, then save ready delayed 3 cycles -> exactly 10 DRAIN cycles; ctx_save_v_o with ctx_id_o=0 held 3 cycles; restore ctx_id_o=2; current ID updates only on restore ready.
- Write d=3 with thread_en_i=4'b0111 -> illegal_o pulse; busy_o stays 0; current ID unchanged. Write d==current -> no outputs toggle.
- drain_timeout_p=4 with pipe_idle_i held 0 -> timeout_o pulse after 4 DRAIN cycles; back to IDLE; no save issued; current ID unchanged. pipe_idle_i rising on the limit cycle -> SAVE, no timeout.
- Second write (d=1) during RESTORE of a switch to d=2 -> ignored; final current_thread_id_o=2; one switch_done_o.
- reset_n_i driven low asynchronously mid-SAVE -> all outputs 0 without a clock edge; after release, state IDLE and current_thread_id_o=0.
